// File: rtl/inv_subbytes_iter.sv
// Iterative AES-128 InvSubBytes: LANES inverse S-boxes walk the state
// from byte 15 down to byte 0, one group of bytes per clock.
module inv_subbytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 &&
        LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [127:0]       work_q;
    logic [127:0]       work_d;
    logic [127:0]       out_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [8*LANES-1:0] sub;
    logic               last;

    assign last      = (cnt_q == CW'(NCYC - 1));
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = busy_q;

    // Lanes always read the top bytes; the register rotates left by
    // LANES bytes per cycle, so after NCYC cycles every byte is home.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        inv_sbox u_sbox (
            .a(work_q[127-8*j -: 8]),
            .c(sub[8*LANES-1-8*j -: 8])
        );
    end

    if (LANES == 16) begin : g_full
        assign work_d = sub;
    end else begin : g_rot
        assign work_d = {work_q[127-8*LANES:0], sub};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last) begin
                        out_q       <= work_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);
    function automatic logic [7:0] gmul(
        input logic [7:0] x,
        input logic [7:0] y
    );
        logic [7:0] p;
        logic [7:0] s;
        p = '0;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] acc;

    // Inverse affine map, then the field inverse as b^254 (0 maps to 0).
    always_comb begin
        b   = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        sq  = gmul(b, b);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        c = acc;
    end
endmodule

// File: tb/tb_inv_subbytes_iter.sv
// Bench for inv_subbytes_iter: literal vectors, handshake corner cases and
// random SubBytes round trips on LANES = 4, 1, 2, 8 and 16.
module tb_inv_subbytes_iter;
    localparam int NI        = 5;
    localparam int LV [NI]   = '{4, 1, 2, 8, 16};
    localparam int NRND      = 600;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [NI];
    logic         ir   [NI];
    logic         ov   [NI];
    logic         ordy [NI];
    logic         bz   [NI];
    logic [127:0] id   [NI];
    logic [127:0] od   [NI];

    logic [7:0] fwd [256];
    logic [7:0] rev [256];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        inv_subbytes_iter #(.LANES(LV[g])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .in_data  (id[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .out_data (od[g]),
            .busy     (bz[g])
        );
    end

    // Reference: field arithmetic by polynomial product and long division.
    function automatic int gm(int a, int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ ('h11B << (i - 8));
        return p;
    endfunction

    function automatic int rl(int v, int k);
        return ((v << k) | (v >> (8 - k))) & 'hFF;
    endfunction

    task automatic build_tables();
        int inv;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gm(x, y) == 1) inv = y;
            s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 'h63;
            fwd[x] = 8'(s);
            rev[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] subbytes(logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd[x[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] invsub(logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = rev[x[8*i +: 8]];
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drives one block through instance d; returns result, latency in edges
    // from accept to out_valid, and whether in_ready stayed low meanwhile.
    task automatic send(input int d, input logic [127:0] x,
                        output logic [127:0] y, output int lat,
                        output bit rdy_low);
        int w;
        w = 0;
        while (!ir[d] && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ir[d]) check($sformatf("ready wait L%0d", LV[d]), 128'(ir[d]), 128'd1);
        iv[d] = 1'b1;
        id[d] = x;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = 0;
        rdy_low = 1'b1;
        while (!ov[d] && lat < 64) begin
            if (ir[d]) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (ir[d]) rdy_low = 1'b0;
        y = od[d];
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
    endtask

    initial begin
        vec_t         tv [6];
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] blk [8];
        int           lat;
        bit           rlow;
        int           sent;
        int           got;
        int           cyc;
        int           last;
        bit           acc;
        bit           tk;

        build_tables();
        for (int d = 0; d < NI; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
            id[d]   = '0;
        end

        // Reset with in_valid held high, then release.
        rst_n = 1'b0;
        iv[0] = 1'b1;
        id[0] = {16{8'hA5}};
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 128'(ir[0]), 128'd0);
        check("reset out_valid", 128'(ov[0]), 128'd0);
        check("reset out_data", od[0], 128'd0);
        check("reset busy", 128'(bz[0]), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("no capture at release", 128'(bz[0]), 128'd0);
        check("ready after release", 128'(ir[0]), 128'd1);
        iv[0] = 1'b0;

        send(0, {16{8'h63}}, y, lat, rlow);
        check("first block data", y, 128'd0);
        check("first block latency", 128'(lat), 128'd4);
        check("first block ready low", 128'(rlow), 128'd1);
        check("idle after handshake", 128'(ir[0]), 128'd1);

        // Literal vectors, including byte-order probes at both ends.
        tv[0] = '{{16{8'h63}}, 128'd0};
        tv[1] = '{128'd0, {16{8'h52}}};
        tv[2] = '{{4{32'h7C16ED63}}, {4{32'h01FF5300}}};
        tv[3] = '{{16{8'h52}}, {16{8'h48}}};
        tv[4] = '{128'h63, {{15{8'h52}}, 8'h00}};
        tv[5] = '{{8'h63, 120'd0}, {8'h00, {15{8'h52}}}};
        for (int i = 0; i < 6; i++) begin
            send(0, tv[i].din, y, lat, rlow);
            check($sformatf("vector %0d data", i), y, tv[i].dout);
            check($sformatf("vector %0d latency", i), 128'(lat), 128'd4);
        end

        // Stall in DONE while the input side toggles.
        x = {$urandom, $urandom, $urandom, $urandom};
        iv[0] = 1'b1;
        id[0] = x;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stall entry valid", 128'(ov[0]), 128'd1);
        for (int i = 0; i < 20; i++) begin
            iv[0] = i[0];
            id[0] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("stall out_valid", 128'(ov[0]), 128'd1);
            check("stall out_data", od[0], invsub(x));
            check("stall busy", 128'(bz[0]), 128'd0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("release drops valid", 128'(ov[0]), 128'd0);
        check("release ready", 128'(ir[0]), 128'd1);
        check("data retained", od[0], invsub(x));

        // Reset during BUSY cycle 2.
        x = {$urandom, $urandom, $urandom, $urandom};
        iv[0] = 1'b1;
        id[0] = x;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset out_valid", 128'(ov[0]), 128'd0);
        check("midreset out_data", od[0], 128'd0);
        check("midreset busy", 128'(bz[0]), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        x = {$urandom, $urandom, $urandom, $urandom};
        send(0, x, y, lat, rlow);
        check("post-reset data", y, invsub(x));
        check("post-reset latency", 128'(lat), 128'd4);

        // Back-to-back with in_valid and out_ready held high.
        for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0;
        got  = 0;
        cyc  = 0;
        last = -1;
        iv[0]   = 1'b1;
        id[0]   = blk[0];
        ordy[0] = 1'b1;
        while (got < 8 && cyc < 200) begin
            acc = iv[0] && ir[0];
            tk  = ov[0];
            if (tk) begin
                check($sformatf("stream %0d data", got), od[0], invsub(blk[got]));
                if (last >= 0)
                    check($sformatf("stream %0d spacing", got), 128'(cyc - last), 128'd6);
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 8) id[0] = blk[sent];
                else iv[0] = 1'b0;
            end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        check("stream result count", 128'(got), 128'd8);

        // Random round trips on every lane count.
        for (int d = 0; d < NI; d++) begin
            for (int n = 0; n < NRND; n++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                send(d, subbytes(x), y, lat, rlow);
                check($sformatf("roundtrip L%0d data", LV[d]), y, x);
                check($sformatf("roundtrip L%0d latency", LV[d]), 128'(lat),
                      128'(16 / LV[d]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
